// File: rtl/ecc_montmul_ws.sv
// Word-serial Montgomery multiplier: res = a*b*R^-1 mod p, R = 2^(RADIX*NUM_WORDS), fully reduced.
// Latency: done_out pulses NUM_WORDS*(NUM_WORDS+2)+1 cycles after the accepted start edge.
// Backpressure: none; start_in is only sampled in IDLE, requests while busy are dropped (no queuing).
module ecc_montmul_ws #(
  parameter int RADIX     = 32,
  parameter int NUM_WORDS = 12
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         zeroize,
  input  logic                         start_in,
  input  logic [RADIX*NUM_WORDS-1:0]   a_in,
  input  logic [RADIX*NUM_WORDS-1:0]   b_in,
  input  logic [RADIX*NUM_WORDS-1:0]   p_in,
  input  logic [RADIX-1:0]             mu_in,
  output logic                         busy_out,
  output logic                         done_out,
  output logic [RADIX*NUM_WORDS-1:0]   res_out
);

  localparam int W   = RADIX;
  localparam int N   = NUM_WORDS;
  localparam int OPW = W * N;
  localparam int DW  = 2 * W + 1;
  localparam int CW  = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MCALC = 3'd1,
    S_ACCUM = 3'd2,
    S_SUB   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Latched operands; later input changes are invisible to the running operation.
  logic [OPW-1:0] a_q, b_q, p_q;
  logic [W-1:0]   mu_q;

  // Running accumulator t (N words plus one overflow bit) and subtraction buffer d.
  logic [OPW-1:0] t_q;
  logic           t_top_q;
  logic [OPW-1:0] d_q;
  logic           borrow_q;

  logic [CW-1:0]  i_q, j_q;
  logic [W-1:0]   m_q;
  logic [W:0]     c_q;

  // Limb selects and arithmetic results.
  logic [W-1:0]   a_j, b_i, p_j, t_j;
  logic [W-1:0]   ab_lo, s0, m_next;
  logic [DW-1:0]  acc_sum;
  logic [W:0]     top_sum;
  logic [W:0]     diff;
  logic           j_last, i_last, use_d;

  // Word selects and the fused PE datapath: a_j*b_i + p_j*m_i + t_j + carry.
  always_comb begin
    a_j     = a_q[int'(j_q) * W +: W];
    p_j     = p_q[int'(j_q) * W +: W];
    t_j     = t_q[int'(j_q) * W +: W];
    b_i     = b_q[int'(i_q) * W +: W];
    ab_lo   = a_j * b_i;
    s0      = t_j + ab_lo;
    m_next  = s0 * mu_q;
    acc_sum = DW'(a_j) * DW'(b_i) + DW'(p_j) * DW'(m_q) + DW'(t_j) + DW'(c_q);
    top_sum = acc_sum[DW-1:W] + {{W{1'b0}}, t_top_q};
    diff    = {1'b0, t_j} - {1'b0, p_j} - {{W{1'b0}}, borrow_q};
    j_last  = (j_q == LAST);
    i_last  = (i_q == LAST);
    use_d   = t_top_q | ~borrow_q;
  end

  // State register: asynchronous reset, synchronous zeroize returns to IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else if (zeroize) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: N x (MCALC + N ACCUM), then N SUB, then one DONE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_in) state_d = S_MCALC;
      S_MCALC: state_d = S_ACCUM;
      S_ACCUM: if (j_last) state_d = i_last ? S_SUB : S_MCALC;
      S_SUB:   if (j_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Busy covers every non-idle cycle, including DONE.
  always_comb begin
    busy_out = (state_q != S_IDLE);
  end

  // Datapath registers: operand latch, accumulation, final subtraction and result load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      mu_q     <= '0;
      t_q      <= '0;
      t_top_q  <= 1'b0;
      d_q      <= '0;
      borrow_q <= 1'b0;
      i_q      <= '0;
      j_q      <= '0;
      m_q      <= '0;
      c_q      <= '0;
      done_out <= 1'b0;
      res_out  <= '0;
    end else if (zeroize) begin
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      mu_q     <= '0;
      t_q      <= '0;
      t_top_q  <= 1'b0;
      d_q      <= '0;
      borrow_q <= 1'b0;
      i_q      <= '0;
      j_q      <= '0;
      m_q      <= '0;
      c_q      <= '0;
      done_out <= 1'b0;
      res_out  <= '0;
    end else begin
      done_out <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_in) begin
            a_q     <= a_in;
            b_q     <= b_in;
            p_q     <= p_in;
            mu_q    <= mu_in;
            t_q     <= '0;
            t_top_q <= 1'b0;
            i_q     <= '0;
            j_q     <= '0;
          end
        end
        S_MCALC: begin
          // j is 0 here, so a_j/t_j select a[0]/t[0].
          m_q <= m_next;
          c_q <= '0;
          j_q <= '0;
        end
        S_ACCUM: begin
          c_q <= acc_sum[DW-1:W];
          // The j=0 low word is zero by choice of m_i; words shift down by one.
          if (j_q != '0) begin
            t_q[(int'(j_q) - 1) * W +: W] <= acc_sum[W-1:0];
          end
          if (j_last) begin
            t_q[(N - 1) * W +: W] <= top_sum[W-1:0];
            t_top_q               <= top_sum[W];
            j_q                   <= '0;
            i_q                   <= i_last ? '0 : i_q + 1'b1;
            borrow_q              <= 1'b0;
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        S_SUB: begin
          d_q[int'(j_q) * W +: W] <= diff[W-1:0];
          borrow_q                <= diff[W];
          j_q                     <= j_last ? '0 : j_q + 1'b1;
        end
        S_DONE: begin
          // t - p is taken when t overflowed R or did not borrow, i.e. t >= p.
          res_out  <= use_d ? d_q : t_q;
          done_out <= 1'b1;
        end
        default: begin
          j_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_montmul_ws.sv
// Bench for ecc_montmul_ws: a small instance (8-bit limbs, 2 words) and a P-384 instance.
// Expected results come from modular arithmetic on wide integers, not from the datapath structure.
// Every wait on the DUT is bounded by a cycle budget.
module tb_ecc_montmul_ws;

  localparam logic [383:0] P384 =
    384'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFFFF_00000000_00000000_FFFFFFFF;
  localparam logic [15:0]  P16 = 16'hFFF1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  // Small instance
  logic        zero_s, start_s, busy_s, done_s;
  logic [15:0] a_s, b_s, p_s, res_s;
  logic [7:0]  mu_s;

  // P-384 instance
  logic         zero_b, start_b, busy_b, done_b;
  logic [383:0] a_b, b_b, p_b, res_b;
  logic [31:0]  mu_b;

  int checks   = 0;
  int failures = 0;

  ecc_montmul_ws #(.RADIX(8), .NUM_WORDS(2)) u_small (
    .clk(clk), .reset_n(reset_n), .zeroize(zero_s), .start_in(start_s),
    .a_in(a_s), .b_in(b_s), .p_in(p_s), .mu_in(mu_s),
    .busy_out(busy_s), .done_out(done_s), .res_out(res_s)
  );

  ecc_montmul_ws u_big (
    .clk(clk), .reset_n(reset_n), .zeroize(zero_b), .start_in(start_b),
    .a_in(a_b), .b_in(b_b), .p_in(p_b), .mu_in(mu_b),
    .busy_out(busy_b), .done_out(done_b), .res_out(res_b)
  );

  task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // a*b*2^-nbits mod p: reduce the product, then halve modulo p nbits times.
  function automatic logic [383:0] mont_ref(input logic [383:0] a, input logic [383:0] b,
                                            input logic [383:0] p, input int nbits);
    logic [383:0] r;
    logic [384:0] x;
    r = 384'(({384'd0, a} * {384'd0, b}) % {384'd0, p});
    x = {1'b0, r};
    for (int k = 0; k < nbits; k++) begin
      if (x[0]) x = x + {1'b0, p};
      x = x >> 1;
    end
    return x[383:0];
  endfunction

  // -p^-1 mod 2^32 by Newton iteration on the low word of p.
  function automatic logic [31:0] calc_mu(input logic [31:0] p0);
    logic [31:0] inv;
    inv = 32'd1;
    for (int k = 0; k < 6; k++) inv = inv * (32'd2 - p0 * inv);
    return 32'd0 - inv;
  endfunction

  function automatic logic [383:0] rand_below(input logic [383:0] p);
    logic [383:0] v;
    for (int k = 0; k < 12; k++) v[k*32 +: 32] = $urandom;
    return v % p;
  endfunction

  task automatic run_s(input logic [15:0] a, input logic [15:0] b, output logic [15:0] r,
                       output int lat, output int bcnt, output logic bdone);
    @(negedge clk);
    a_s = a; b_s = b; start_s = 1'b1;
    @(posedge clk);
    #1 start_s = 1'b0;
    bcnt = busy_s ? 1 : 0;
    lat  = 0;
    while (lat < 60) begin
      @(posedge clk);
      #1 lat++;
      if (done_s) break;
      if (busy_s) bcnt++;
    end
    r     = res_s;
    bdone = busy_s;
  endtask

  task automatic run_b(input logic [383:0] a, input logic [383:0] b, output logic [383:0] r,
                       output int lat);
    @(negedge clk);
    a_b = a; b_b = b; start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    lat = 0;
    while (lat < 400) begin
      @(posedge clk);
      #1 lat++;
      if (done_b) break;
    end
    r = res_b;
  endtask

  initial begin
    logic [15:0]  r16, ra, rb;
    logic [383:0] r384, ea, eb;
    int           lat, bc, ndone, first;
    logic         bd;

    reset_n = 1'b0;
    zero_s = 1'b0; start_s = 1'b0; a_s = '0; b_s = '0;
    zero_b = 1'b0; start_b = 1'b0; a_b = '0; b_b = '0;
    p_s  = P16;  mu_s = 8'(calc_mu({16'd0, P16}));
    p_b  = P384; mu_b = calc_mu(P384[31:0]);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst_busy_s", 384'(busy_s), 384'd0);
    check("rst_done_s", 384'(done_s), 384'd0);
    check("rst_res_s",  384'(res_s),  384'd0);
    check("rst_busy_b", 384'(busy_b), 384'd0);
    check("rst_res_b",  res_b,        384'd0);

    // Zero operand, with a stray start while busy that must be dropped.
    @(negedge clk);
    a_s = 16'h0000; b_s = 16'hABCD; start_s = 1'b1;
    @(posedge clk);
    #1 start_s = 1'b0;
    ndone = 0; first = 0; r16 = 16'hFFFF;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done_s) begin
        ndone++;
        if (first == 0) begin first = k; r16 = res_s; end
      end
      if (k == 3) start_s = 1'b1;
      if (k == 4) start_s = 1'b0;
    end
    check("ign_ndone", 384'(ndone), 384'd1);
    check("ign_lat",   384'(first), 384'd9);
    check("ign_res",   384'(r16),   384'd0);
    check("ign_idle",  384'(busy_s), 384'd0);

    // Directed values for p = 0xFFF1, R = 2^16.
    run_s(16'h000F, 16'h1234, r16, lat, bc, bd);
    check("rmodp_res",  384'(r16), 384'h1234);
    check("rmodp_lat",  384'(lat), 384'd9);
    check("rmodp_busy", 384'(bc),  384'd9);
    check("rmodp_bdn",  384'(bd),  384'd0);
    run_s(16'h0001, 16'h00E1, r16, lat, bc, bd);
    check("r2_res", 384'(r16), 384'h000F);
    run_s(16'hFFF0, 16'hFFF0, r16, lat, bc, bd);
    check("pm1_res", 384'(r16), 384'hEEE1);
    check("pm1_lat", 384'(lat), 384'd9);

    // Zeroize during ACCUM clears outputs at once.
    @(negedge clk);
    a_s = 16'hFFF0; b_s = 16'h1111; start_s = 1'b1;
    @(posedge clk);
    #1 start_s = 1'b0;
    @(posedge clk);
    #1 zero_s = 1'b1;
    @(posedge clk);
    #1 zero_s = 1'b0;
    check("zer_busy", 384'(busy_s), 384'd0);
    check("zer_done", 384'(done_s), 384'd0);
    check("zer_res",  384'(res_s),  384'd0);
    repeat (12) @(posedge clk);
    #1 check("zer_quiet", 384'(done_s | busy_s), 384'd0);

    // Zeroize and start together: nothing starts.
    @(negedge clk);
    zero_s = 1'b1; start_s = 1'b1; a_s = 16'h000F; b_s = 16'h1234;
    @(posedge clk);
    #1 zero_s = 1'b0; start_s = 1'b0;
    check("zst_busy", 384'(busy_s), 384'd0);
    run_s(16'h000F, 16'h1234, r16, lat, bc, bd);
    check("post_zer_res", 384'(r16), 384'h1234);
    check("post_zer_lat", 384'(lat), 384'd9);

    // Asynchronous reset during SUB.
    @(negedge clk);
    a_s = 16'hFFF0; b_s = 16'hFFF0; start_s = 1'b1;
    @(posedge clk);
    #1 start_s = 1'b0;
    repeat (6) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("ars_busy", 384'(busy_s), 384'd0);
    check("ars_done", 384'(done_s), 384'd0);
    check("ars_res",  384'(res_s),  384'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_s(16'h000F, 16'h1234, r16, lat, bc, bd);
    check("post_rst_res", 384'(r16), 384'h1234);
    check("post_rst_lat", 384'(lat), 384'd9);

    // Random small vectors against the reference.
    for (int v = 0; v < 10; v++) begin
      ra = 16'($urandom % 32'(P16));
      rb = 16'($urandom % 32'(P16));
      run_s(ra, rb, r16, lat, bc, bd);
      check("rnd_s_res", 384'(r16), mont_ref({368'd0, ra}, {368'd0, rb}, {368'd0, P16}, 16));
      check("rnd_s_lat", 384'(lat), 384'd9);
    end

    // P-384 corner cases.
    run_b(384'd0, P384 - 384'd1, r384, lat);
    check("big_zero", r384, 384'd0);
    check("big_zero_lat", 384'(lat), 384'd169);
    run_b(P384 - 384'd1, P384 - 384'd1, r384, lat);
    check("big_pm1", r384, mont_ref(P384 - 384'd1, P384 - 384'd1, P384, 384));
    run_b(384'd1, 384'd1, r384, lat);
    check("big_one", r384, mont_ref(384'd1, 384'd1, P384, 384));

    // Random P-384 vectors.
    for (int v = 0; v < 250; v++) begin
      ea = rand_below(P384);
      eb = rand_below(P384);
      run_b(ea, eb, r384, lat);
      check("rnd_b_res", r384, mont_ref(ea, eb, P384, 384));
      check("rnd_b_lat", 384'(lat), 384'd169);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
